// File: rtl/ks_note_sequencer.sv
// Step-table note sequencer driving the Karplus-Strong period/pluck controls.
// Optional macro KS_SEQ_HUMANIZE_EN adds a saturating +prbs_bit detune to each loaded period.
module ks_note_sequencer #(
   parameter int KS_DATA_WIDTH = 8,
   parameter int NUM_STEPS     = 8,
   parameter int STEP_AW       = 3,
   parameter int DUR_WIDTH     = 12,
   parameter int PLUCK_TICKS   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_tick,
   input  logic                     seq_en,
   input  logic                     seq_loop,
   input  logic                     wr_en,
   input  logic [STEP_AW-1:0]       wr_addr,
   input  logic [KS_DATA_WIDTH-1:0] wr_period,
   input  logic [DUR_WIDTH-1:0]     wr_dur,
   input  logic [KS_DATA_WIDTH-1:0] manual_period,
   input  logic                     manual_pluck,
   input  logic                     prbs_bit,
   output logic [KS_DATA_WIDTH-1:0] ks_period,
   output logic                     ks_pluck,
   output logic                     busy,
   output logic [STEP_AW-1:0]       step_idx,
   output logic                     done
);

   localparam int                   PCNT_W    = $clog2(PLUCK_TICKS + 1);
   localparam logic [PCNT_W-1:0]    PLUCK_INI = PCNT_W'(PLUCK_TICKS);
   localparam logic [STEP_AW-1:0]   LAST_STEP = STEP_AW'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLUCK,
      S_HOLD,
      S_NEXT,
      S_END
   } state_e;

   state_e                   state_q, state_d;
   logic                     seq_en_q;
   logic [STEP_AW-1:0]       step_idx_q, step_idx_d;
   logic [DUR_WIDTH-1:0]     cnt_q, cnt_d;
   logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
   logic [KS_DATA_WIDTH-1:0] ks_period_q, ks_period_d;
   logic                     ks_pluck_q, ks_pluck_d;
   logic                     done_q, done_d;

   logic [KS_DATA_WIDTH-1:0] tbl_period_q [NUM_STEPS];
   logic [DUR_WIDTH-1:0]     tbl_dur_q    [NUM_STEPS];

   logic [KS_DATA_WIDTH-1:0] rd_period;
   logic [DUR_WIDTH-1:0]     rd_dur;
   logic [KS_DATA_WIDTH-1:0] load_period;
   logic [DUR_WIDTH-1:0]     cnt_dec;
   logic [PCNT_W-1:0]        pcnt_dec;

   // NOTE: the table is a register file with reset, not a RAM, so every entry must start at a known value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            tbl_period_q[i] <= '0;
            tbl_dur_q[i]    <= '0;
         end
      end else if (wr_en) begin
         tbl_period_q[wr_addr] <= wr_period;
         tbl_dur_q[wr_addr]    <= wr_dur;
      end
   end

   // Combinational read sees the pre-write contents when a write hits the same entry.
   assign rd_period = tbl_period_q[step_idx_q];
   assign rd_dur    = tbl_dur_q[step_idx_q];

`ifdef KS_SEQ_HUMANIZE_EN
   localparam int SUM_W = KS_DATA_WIDTH + 1;
   logic [SUM_W-1:0] detune_sum;
   assign detune_sum  = {1'b0, rd_period} + SUM_W'(prbs_bit);
   assign load_period = detune_sum[KS_DATA_WIDTH] ? '1 : detune_sum[KS_DATA_WIDTH-1:0];
`else
   logic prbs_unused;
   assign prbs_unused = prbs_bit;
   assign load_period = rd_period;
`endif

   // Counters floor at zero instead of wrapping.
   assign cnt_dec  = (cnt_q  == '0) ? '0 : cnt_q  - DUR_WIDTH'(1);
   assign pcnt_dec = (pcnt_q == '0) ? '0 : pcnt_q - PCNT_W'(1);

   // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         seq_en_q    <= 1'b0;
         step_idx_q  <= '0;
         cnt_q       <= '0;
         pcnt_q      <= '0;
         ks_period_q <= '0;
         ks_pluck_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_en_q    <= seq_en;
         step_idx_q  <= step_idx_d;
         cnt_q       <= cnt_d;
         pcnt_q      <= pcnt_d;
         ks_period_q <= ks_period_d;
         ks_pluck_q  <= ks_pluck_d;
         done_q      <= done_d;
      end
   end

   // NOTE: every signal gets a default before the case, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      step_idx_d  = step_idx_q;
      cnt_d       = cnt_q;
      pcnt_d      = pcnt_q;
      ks_period_d = ks_period_q;
      ks_pluck_d  = ks_pluck_q;
      done_d      = 1'b0;

      if (state_q != S_IDLE && !seq_en) begin
         // Abort outranks every other transition and never reports done.
         state_d    = S_IDLE;
         ks_pluck_d = 1'b0;
         step_idx_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               ks_period_d = manual_period;
               ks_pluck_d  = manual_pluck;
               step_idx_d  = '0;
               if (seq_en && !seq_en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
               ks_period_d = load_period;
               cnt_d       = rd_dur;
               pcnt_d      = PLUCK_INI;
               if (rd_dur == '0) begin
                  ks_pluck_d = 1'b0;
                  state_d    = S_END;
               end else begin
                  ks_pluck_d = 1'b1;
                  state_d    = S_PLUCK;
               end
            end
            S_PLUCK: begin
               if (sample_tick) begin
                  cnt_d  = cnt_dec;
                  pcnt_d = pcnt_dec;
                  if (cnt_dec == '0) begin
                     ks_pluck_d = 1'b0;
                     state_d    = S_NEXT;
                  end else if (pcnt_dec == '0) begin
                     ks_pluck_d = 1'b0;
                     state_d    = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (sample_tick) begin
                  cnt_d = cnt_dec;
                  if (cnt_dec == '0) state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               if (step_idx_q == LAST_STEP) begin
                  state_d = S_END;
               end else begin
                  step_idx_d = step_idx_q + STEP_AW'(1);
                  state_d    = S_LOAD;
               end
            end
            S_END: begin
               done_d     = 1'b1;
               step_idx_d = '0;
               state_d    = seq_loop ? S_LOAD : S_IDLE;
            end
            default: begin
               state_d    = S_IDLE;
               ks_pluck_d = 1'b0;
               step_idx_d = '0;
            end
         endcase
      end
   end

   assign ks_period = ks_period_q;
   assign ks_pluck  = ks_pluck_q;
   assign busy      = (state_q != S_IDLE);
   assign step_idx  = step_idx_q;
   assign done      = done_q;

endmodule
